// File: rtl/demux1_2_32bit_stream.sv
// demux1_2_32bit_stream: routes a 32-bit word stream to one of two consumers.
// Each destination has a private FIFO of DEPTH entries, so a stalled consumer
// only blocks words addressed to it.
// Optional feature macro: DEMUX_STATS_EN adds saturating delivered-word
// counters count0/count1 of width CW.
module demux1_2_32bit_stream #(
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [31:0]   out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [31:0]   out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [31:0] mem    [2][DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   occ    [2];

  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  // Per-channel status flags and the handshake decode for both sides.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      full[k]     = (occ[k] == FULL_OCC);
      nonempty[k] = (occ[k] != '0);
    end
    // A pop from a full FIFO does not make room for a push in the same cycle.
    in_ready = reset_n && !full[in_sel];
    accept   = in_valid && in_ready;
    push[0]  = accept && !in_sel;
    push[1]  = accept && in_sel;
    pop[0]   = nonempty[0] && out0_ready;
    pop[1]   = nonempty[1] && out1_ready;
  end

  assign out0_valid = nonempty[0];
  assign out1_valid = nonempty[1];
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];

  // FIFO storage, pointers and occupancy for both channels; reset wipes storage too.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem[k][e] <= 32'h0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= in_data;
          wr_ptr[k]         <= wr_ptr[k] + AW'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   occ[k] <= occ[k] + (AW+1)'(1);
          2'b01:   occ[k] <= occ[k] - (AW+1)'(1);
          default: occ[k] <= occ[k];
        endcase
      end
    end
  end

`ifdef DEMUX_STATS_EN
  // Saturating counts of words handed to each consumer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count0 <= '0;
      count1 <= '0;
    end else begin
      if (pop[0] && (count0 != {CW{1'b1}})) begin
        count0 <= count0 + CW'(1);
      end
      if (pop[1] && (count1 != {CW{1'b1}})) begin
        count1 <= count1 + CW'(1);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_demux1_2_32bit_stream.sv
// Testbench for demux1_2_32bit_stream: a table of directed vectors followed by
// hand-written sequences for streaming, the full-FIFO case, mid-operation reset
// and, when DEMUX_STATS_EN is defined, counter saturation.
module tb_demux1_2_32bit_stream;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [3:0]  count0;
  logic [3:0]  count1;
`endif

  int checks = 0;
  int errors = 0;

  demux1_2_32bit_stream #(
    .DEPTH(2)
`ifdef DEMUX_STATS_EN
    , .CW(4)
`endif
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
    , .count0   (count0),
    .count1     (count1)
`endif
  );

  // 10-unit clock: rising edges at 5, 15, 25...; inputs change on falling edges.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic        sel;
    logic [31:0] data;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vecs [13];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Waits for the falling edge, drives one cycle of inputs and settles.
  task automatic apply_stimulus(input logic iv, input logic sel, input logic [31:0] data,
                                input logic r0, input logic r1);
    @(negedge clock);
    in_valid   = iv;
    in_sel     = sel;
    in_data    = data;
    out0_ready = r0;
    out1_ready = r1;
    #1;
  endtask

  initial begin
    // Table: outputs expected just before the rising edge of each step.
    //          iv  sel data          r0  r1  rdy v0  d0            v1  d1
    vecs[0]  = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{1, 0, 32'hDEADBEEF, 1, 1, 1, 0, 32'h0,        0, 32'h0};
    vecs[2]  = '{1, 1, 32'h12345678, 1, 1, 1, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[3]  = '{0, 1, 32'h0,        1, 1, 1, 0, 32'h0,        1, 32'h12345678};
    vecs[4]  = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0};
    vecs[5]  = '{1, 0, 32'hA0000001, 0, 1, 1, 0, 32'h0,        0, 32'h0};
    vecs[6]  = '{1, 0, 32'hA0000002, 0, 1, 1, 1, 32'hA0000001, 0, 32'h0};
    vecs[7]  = '{1, 0, 32'hA0000003, 0, 1, 0, 1, 32'hA0000001, 0, 32'h0};
    vecs[8]  = '{1, 1, 32'hB0000001, 0, 1, 1, 1, 32'hA0000001, 0, 32'h0};
    vecs[9]  = '{1, 1, 32'hB0000002, 0, 1, 1, 1, 32'hA0000001, 1, 32'hB0000001};
    vecs[10] = '{0, 1, 32'h0,        1, 1, 1, 1, 32'hA0000001, 1, 32'hB0000002};
    vecs[11] = '{0, 1, 32'h0,        1, 1, 1, 1, 32'hA0000002, 0, 32'h0};
    vecs[12] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0};

    reset_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'h0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    check_output("reset_in_ready", {31'h0, in_ready}, 32'h0);
    check_output("reset_out0_valid", {31'h0, out0_valid}, 32'h0);
    check_output("reset_out1_valid", {31'h0, out1_valid}, 32'h0);
    check_output("reset_out0_data", out0_data, 32'h0);
    check_output("reset_out1_data", out1_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
      check_output($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].e_rdy});
      check_output($sformatf("vec%0d_out0_valid", i), {31'h0, out0_valid}, {31'h0, vecs[i].e_v0});
      check_output($sformatf("vec%0d_out1_valid", i), {31'h0, out1_valid}, {31'h0, vecs[i].e_v1});
      if (vecs[i].e_v0) check_output($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].e_d0);
      if (vecs[i].e_v1) check_output($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].e_d1);
    end

    // Stream 1..10 to out1: each word must appear exactly one edge after its accept.
    for (int i = 0; i <= 11; i++) begin
      apply_stimulus(i < 10, 1'b1, 32'(i + 1), 1'b1, 1'b1);
      check_output($sformatf("stream%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
      check_output($sformatf("stream%0d_out0_valid", i), {31'h0, out0_valid}, 32'h0);
      if (i >= 1 && i <= 10) begin
        check_output($sformatf("stream%0d_out1_valid", i), {31'h0, out1_valid}, 32'h1);
        check_output($sformatf("stream%0d_out1_data", i), out1_data, 32'(i));
      end else begin
        check_output($sformatf("stream%0d_out1_valid", i), {31'h0, out1_valid}, 32'h0);
      end
    end

    // Fill out0, then pop and push together: the push must wait one cycle.
    apply_stimulus(1'b1, 1'b0, 32'hC0000001, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 32'hC0000002, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 32'hC0000003, 1'b1, 1'b1);
    check_output("full_in_ready", {31'h0, in_ready}, 32'h0);
    check_output("full_head", out0_data, 32'hC0000001);
    apply_stimulus(1'b1, 1'b0, 32'hC0000003, 1'b1, 1'b1);
    check_output("after_pop_in_ready", {31'h0, in_ready}, 32'h1);
    check_output("after_pop_head", out0_data, 32'hC0000002);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_output("late_push_valid", {31'h0, out0_valid}, 32'h1);
    check_output("late_push_head", out0_data, 32'hC0000003);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_output("drained_out0_valid", {31'h0, out0_valid}, 32'h0);

    // Reset mid-operation with one word held in each FIFO.
    apply_stimulus(1'b1, 1'b0, 32'hD0000000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 32'hD0000001, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_output("preload_out0_valid", {31'h0, out0_valid}, 32'h1);
    check_output("preload_out1_valid", {31'h0, out1_valid}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_output("midrst_out0_valid", {31'h0, out0_valid}, 32'h0);
    check_output("midrst_out1_valid", {31'h0, out1_valid}, 32'h0);
    check_output("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    check_output("midrst_out0_data", out0_data, 32'h0);
    check_output("midrst_out1_data", out1_data, 32'h0);
    #1;
    reset_n = 1'b1;
    #1;
    check_output("release_in_ready", {31'h0, in_ready}, 32'h1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_output("stale_out0_valid", {31'h0, out0_valid}, 32'h0);
    check_output("stale_out1_valid", {31'h0, out1_valid}, 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'hE0000001, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_output("post_rst_out1_valid", {31'h0, out1_valid}, 32'h1);
    check_output("post_rst_out1_data", out1_data, 32'hE0000001);
    check_output("post_rst_out0_valid", {31'h0, out0_valid}, 32'h0);

`ifdef DEMUX_STATS_EN
    // Fresh reset, then 17 deliveries on out0 saturate the 4-bit counter at 15.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(i < 17, 1'b0, 32'(32'hF0 + i), 1'b1, 1'b1);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_output("count0_saturated", {28'h0, count0}, 32'd15);
    check_output("count1_idle", {28'h0, count1}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_output("count0_reset", {28'h0, count0}, 32'd0);
    check_output("count1_reset", {28'h0, count1}, 32'd0);
    reset_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1_2_32bit_stream.md
# demux1_2_32bit_stream

- Routes a stream of 32-bit words from one producer to one of two consumers, selected per word by `in_sel`.
- It is the inverse of the 2:1 32-bit word mux: one source fans out to two destinations.
- Each destination has its own small FIFO, so a stalled consumer blocks only traffic addressed to it.
- The block sits between the datapath write-back source and two downstream sinks, for example the register-file write port and the memory/store path.

## Interface

Parameters:
- `DEPTH`, default 2: entries per output FIFO. Must be a power of two and at least 2.
- `CW`, default 16: width of the optional delivered-word counters.

Ports:
- `clock`  input  1  single system clock; all state updates on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  producer has a word.
- `in_ready`  output  1  block accepts the word this cycle.
- `in_data`  input  32  word to route.
- `in_sel`  input  1  destination: 0 routes to out0, 1 routes to out1.
- `out0_valid`  output  1  out0 FIFO head is valid.
- `out0_ready`  input  1  consumer 0 takes the head.
- `out0_data`  output  32  out0 FIFO head word.
- `out1_valid`  output  1  out1 FIFO head is valid.
- `out1_ready`  input  1  consumer 1 takes the head.
- `out1_data`  output  32  out1 FIFO head word.
- `count0`  output  CW  words delivered on out0. Present only with `DEMUX_STATS_EN`.
- `count1`  output  CW  words delivered on out1. Present only with `DEMUX_STATS_EN`.

## Operation

- Accept: the input transfer occurs on a `clock` edge where `in_valid && in_ready`. `in_data` is pushed into FIFO[`in_sel`].
- `in_ready` is combinational: `reset_n && !full[in_sel]`.
  - A pop from a full FIFO in the same cycle does not free space for a push in that cycle; there is no pass-through.
- Deliver: an output transfer occurs on an edge where `outK_valid && outK_ready`, and pops FIFO K.
  - `outK_valid = (occupancy_K != 0)`.
  - `outK_data` is the head entry. It is held stable while `outK_valid && !outK_ready`.
- Each FIFO has its own `wr_ptr`, `rd_ptr`, and `occupancy` counters.
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `occupancy` is log2(DEPTH)+1 bits wide and ranges 0..DEPTH.
  - `full` means occupancy == DEPTH.
- Simultaneous push and pop on the same non-full, non-empty FIFO: occupancy is unchanged and both pointers advance.
- Simultaneous push to FIFO 0 and pop from FIFO 1, or the reverse, are independent.
- Ordering: words are delivered in acceptance order within each channel. There is no ordering guarantee across channels.
- `in_sel` and `in_data` matter only when `in_valid` is high. A change of `in_sel` while `in_ready` is 0 is legal and re-evaluates `in_ready` in the same cycle.
- Nothing is ever dropped or duplicated.
- Reset, whether asserted idle or mid-operation, clears all state immediately, independent of `clock`:
  - all pointers and occupancies go to 0;
  - `out0_valid` = `out1_valid` = 0;
  - `out0_data` = `out1_data` = 32'h0, because storage is cleared;
  - `in_ready` = 0 while `reset_n` is low;
  - `count0` = `count1` = 0.
  - Words held in the FIFOs are lost.

## Timing

- Latency: a word accepted at edge N appears on `outK_valid`/`outK_data` after edge N, so it is deliverable at edge N+1 at the earliest.
- Throughput: one word per cycle in, and one word per cycle per output, provided the selected FIFO is not full.
- On release of `reset_n`, `in_ready` rises combinationally. The first accept can happen at the first `clock` edge after deassertion.
- Combinational paths:
  - `in_sel` → `in_ready`;
  - `reset_n` → `in_ready`.
  - There is no combinational path from `outK_ready` to `in_ready`, or from `in_*` to `out*`.

## Configuration

- Macro: `DEMUX_STATS_EN`.
- When defined, the ports `count0`/`count1` exist.
  - `countK` increments by 1 on each out-K transfer.
  - It saturates at 2^CW−1 and does not wrap.
  - It resets to 0 asynchronously.
- When undefined, the ports and counter logic are absent. Routing behaviour is identical.

## Test plan

- Basic route: push 32'hDEADBEEF with sel=0, then 32'h12345678 with sel=1, with both readies held at 1.
  - → out0 delivers DEADBEEF one edge after its accept, and out1 delivers 12345678 one edge after its accept.
  - → No cross-delivery.
- Backpressure isolation, DEPTH=2: hold `out0_ready`=0 and push 3 words with sel=0.
  - → `in_ready` drops to 0 after 2 accepts.
  - → Switching `in_sel` to 1 raises `in_ready` in the same cycle, and the out1 words still flow.
  - → Releasing `out0_ready` yields the first two words in order.
- Wrap and simultaneous push/pop: stream 10 words 1..10 to out1 with `out1_ready`=1 throughout.
  - → 10 words are delivered in order at one per cycle.
  - → Occupancy never exceeds 1, and the pointers wrap without error.
- Full, no pass-through: fill out0 (2 words), then present a pop and a push to channel 0 in the same cycle.
  - → The push is not accepted that cycle (`in_ready`=0). It is accepted on the next cycle.
- Reset mid-operation: with 1 word in each FIFO, pulse `reset_n` low between clock edges.
  - → Both valids and `in_ready` go to 0 immediately.
  - → After release, no stale word is delivered and the first new word routes correctly.
- With `DEMUX_STATS_EN` and CW=4: deliver 17 words on out0.
  - → `count0` = 15 (saturated) and `count1` = 0.
  - → Reset clears both counters to 0.
